// File: rtl/binary_subtractor_32_bit_if.sv
// Operand/result bundle for the digit-serial subtractor.
// The master drives the request side; the slave returns the result and the flags.
interface binary_subtractor_32_bit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, ovf, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, ovf, zero
    );
endinterface

// File: rtl/binary_subtractor_32_bit.sv
// Digit-serial subtractor: d = a - b - bin, processed DIGIT bits per clock, LSD first,
// with the borrow carried between cycles. Result and flags are held until the next completion.
module binary_subtractor_32_bit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    binary_subtractor_32_bit_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT:0]   w_diff;
    logic [WIDTH-1:0] w_res_next;

    // The extra top bit of the DIGIT+1 wide difference is the borrow out of this digit.
    assign w_diff     = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]} - {{DIGIT{1'b0}}, r_borrow};
    assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_diff[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign w_last     = (r_cnt == CW'(NDIG - 1));

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_d      <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_sign_a <= bus.a[WIDTH-1];
                r_sign_b <= bus.b[WIDTH-1];
                r_borrow <= bus.bin;
                r_res    <= '0;
                r_cnt    <= '0;
            end else if (r_state == RUN) begin
                r_a      <= r_a >> DIGIT;
                r_b      <= r_b >> DIGIT;
                r_borrow <= w_diff[DIGIT];
                r_res    <= w_res_next;
                r_cnt    <= r_cnt + CW'(1);
                if (w_last) begin
                    r_d    <= w_res_next;
                    r_bout <= w_diff[DIGIT];
                    r_ovf  <= (r_sign_a ^ r_sign_b) & (w_res_next[WIDTH-1] ^ r_sign_a);
                    r_zero <= ~|w_res_next;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
    assign bus.d    = r_d;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;
endmodule

// File: tb/tb_binary_subtractor_32_bit.sv
// Scoreboard bench for the digit-serial subtractor, plus DIGIT=1 and DIGIT=32 instances.
module tb_binary_subtractor_32_bit;
    typedef struct packed {
        logic [31:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    binary_subtractor_32_bit_if #(.WIDTH(32)) bus   ();
    binary_subtractor_32_bit_if #(.WIDTH(32)) bus1  ();
    binary_subtractor_32_bit_if #(.WIDTH(32)) bus32 ();

    binary_subtractor_32_bit #(.WIDTH(32), .DIGIT(8))  dut   (.clk(clk), .reset(reset), .bus(bus));
    binary_subtractor_32_bit #(.WIDTH(32), .DIGIT(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1));
    binary_subtractor_32_bit #(.WIDTH(32), .DIGIT(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    res_t        sb[$];
    logic        prev_done = 1'b0;

    always @(posedge clk) cyc++;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] full;
        res_t        r;
        full   = {1'b0, a} - {1'b0, b} - {32'b0, bin};
        r.d    = full[31:0];
        r.bout = full[32];
        r.ovf  = (a[31] != b[31]) && (r.d[31] != a[31]);
        r.zero = (r.d == 32'd0);
        return r;
    endfunction

    // Result monitor: every done pops one expectation from the scoreboard.
    always @(negedge clk) begin : monitor
        res_t e;
        res_t g;
        if (bus.done === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done=1 with no pending operation, required done=0");
            end else begin
                e = sb.pop_front();
                g = {bus.d, bus.bout, bus.ovf, bus.zero};
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL result: got d=%h bout=%b ovf=%b zero=%b, required d=%h bout=%b ovf=%b zero=%b",
                             g.d, g.bout, g.ovf, g.zero, e.d, e.bout, e.ovf, e.zero);
                end
            end
            n_checks++;
            if (prev_done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse: done high %0d cycles in a row, required 1", 2);
            end
        end
        prev_done = bus.done;
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input int exp_lat, output int done_cyc);
        int lat;
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        bus.start = 1'b1;
        @(posedge clk);
        sb.push_back(model(a, b, bin));
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.done === 1'b1) break;
        end
        done_cyc = int'(cyc);
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL latency: a=%h b=%h got %0d cycles, required %0d", a, b, lat, exp_lat);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if ({bus.busy, bus.done, bus.d, bus.bout, bus.ovf, bus.zero} !== 37'd0) begin
            n_fail++;
            $display("FAIL %s: got busy=%b done=%b d=%h bout=%b ovf=%b zero=%b, required all 0",
                     name, bus.busy, bus.done, bus.d, bus.bout, bus.ovf, bus.zero);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_held");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset_released");
    endtask

    task automatic test_directed();
        int c;
        run_op(32'hAAAAAAAA, 32'h55555555, 1'b0, 4, c);
        run_op(32'h00000000, 32'h00000001, 1'b0, 4, c);
        run_op(32'h12345678, 32'h12345678, 1'b0, 4, c);
        run_op(32'h12345678, 32'h12345678, 1'b1, 4, c);
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 4, c);
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 4, c);
    endtask

    task automatic test_back_to_back();
        int c1;
        int c2;
        run_op(32'h80000000, 32'h00000001, 1'b0, 4, c1);
        run_op(32'h00000005, 32'h00000003, 1'b0, 4, c2);
        n_checks++;
        if (c2 - c1 !== 5) begin
            n_fail++;
            $display("FAIL back_to_back_gap: got %0d cycles between done pulses, required 5", c2 - c1);
        end
    endtask

    task automatic test_ignore_busy();
        int   lat;
        logic seen;
        @(negedge clk);
        bus.a     = 32'hFFFF0000;
        bus.b     = 32'h0000FFFF;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        sb.push_back(model(32'hFFFF0000, 32'h0000FFFF, 1'b0));
        @(negedge clk);
        bus.a   = 32'h12345678;
        bus.b   = 32'h0F0F0F0F;
        bus.bin = 1'b1;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_running: got busy=%b, required 1", bus.busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (lat < 10 && !seen) begin
            @(posedge clk);
            lat++;
            #1;
            seen = (bus.done === 1'b1);
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_busy_done: got no done in %0d cycles, required done", lat);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start_queued: got busy=%b after completion, required 0", bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        logic seen;
        @(negedge clk);
        bus.a     = 32'hFFFF0000;
        bus.b     = 32'h0000FFFF;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("reset_abort");
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_done: got done=1 after aborted operation, required 0");
        end
    endtask

    task automatic test_random();
        int          c;
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        for (int i = 0; i < 10000; i++) begin
            a   = $urandom;
            b   = $urandom;
            bin = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) b = a;
            run_op(a, b, bin, 4, c);
        end
    endtask

    task automatic test_digit_builds();
        logic [31:0] va [6] = '{32'hAAAAAAAA, 32'h00000000, 32'h12345678, 32'h80000000, 32'hFFFF0000, 32'hFFFFFFFF};
        logic [31:0] vb [6] = '{32'h55555555, 32'h00000001, 32'h12345678, 32'h00000001, 32'h0000FFFF, 32'hFFFFFFFF};
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        res_t        e;
        int          lat;
        int          lat1;
        int          lat32;
        for (int i = 0; i < 20; i++) begin
            a   = (i < 6) ? va[i] : $urandom;
            b   = (i < 6) ? vb[i] : $urandom;
            bin = 1'(i % 2);
            e   = model(a, b, bin);
            @(negedge clk);
            bus1.a  = a;  bus1.b  = b;  bus1.bin  = bin;  bus1.start  = 1'b1;
            bus32.a = a;  bus32.b = b;  bus32.bin = bin;  bus32.start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus1.start  = 1'b0;
            bus32.start = 1'b0;
            lat   = 0;
            lat1  = 0;
            lat32 = 0;
            while (lat < 40 && lat1 == 0) begin
                @(posedge clk);
                lat++;
                #1;
                if (bus32.done === 1'b1) begin
                    lat32 = lat;
                    n_checks++;
                    if ({bus32.d, bus32.bout, bus32.ovf, bus32.zero} !== e) begin
                        n_fail++;
                        $display("FAIL digit32_result: got d=%h bout=%b ovf=%b zero=%b, required d=%h bout=%b ovf=%b zero=%b",
                                 bus32.d, bus32.bout, bus32.ovf, bus32.zero, e.d, e.bout, e.ovf, e.zero);
                    end
                end
                if (bus1.done === 1'b1) begin
                    lat1 = lat;
                    n_checks++;
                    if ({bus1.d, bus1.bout, bus1.ovf, bus1.zero} !== e) begin
                        n_fail++;
                        $display("FAIL digit1_result: got d=%h bout=%b ovf=%b zero=%b, required d=%h bout=%b ovf=%b zero=%b",
                                 bus1.d, bus1.bout, bus1.ovf, bus1.zero, e.d, e.bout, e.ovf, e.zero);
                    end
                end
            end
            n_checks++;
            if (lat32 !== 1 || lat1 !== 32) begin
                n_fail++;
                $display("FAIL digit_build_latency: got DIGIT=32 %0d, DIGIT=1 %0d cycles, required 1 and 32", lat32, lat1);
            end
        end
    endtask

    initial begin
        bus.start   = 1'b0;  bus.a   = '0;  bus.b   = '0;  bus.bin   = 1'b0;
        bus1.start  = 1'b0;  bus1.a  = '0;  bus1.b  = '0;  bus1.bin  = 1'b0;
        bus32.start = 1'b0;  bus32.a = '0;  bus32.b = '0;  bus32.bin = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        test_random();
        test_digit_builds();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d results never produced, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
